// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: scoreboard-based operand forwarding and load-use stall detection
module pipe_hazard_unit #(
  parameter int DATA_W   = 64,
  parameter int AW       = 5,
  parameter int STAGES   = 3,
  parameter int LOAD_LAT = 1,
  parameter int ZERO_REG = 31,
  parameter int LINK_REG = 30
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       issue_valid,
  input  logic [AW-1:0]              issue_rd,
  input  logic                       issue_wr,
  input  logic                       issue_load,
  input  logic                       issue_link,
  input  logic [AW-1:0]              src_a,
  input  logic [AW-1:0]              src_b,
  input  logic                       src_a_used,
  input  logic                       src_b_used,
  input  logic                       flush,
  input  logic [STAGES*DATA_W-1:0]   stage_data,
  output logic                       stall,
  output logic                       fwd_a_hit,
  output logic                       fwd_b_hit,
  output logic [DATA_W-1:0]          fwd_a_data,
  output logic [DATA_W-1:0]          fwd_b_data,
  output logic [15:0]                stall_count,
  output logic [$clog2(STAGES+1)-1:0] inflight
);
  localparam int IW = $clog2(STAGES+1);
  localparam logic [AW-1:0] ZR = AW'(ZERO_REG);
  localparam logic [AW-1:0] LR = AW'(LINK_REG);

  logic [STAGES-1:0] entValid;
  logic [STAGES-1:0] entLoad;
  logic [AW-1:0]     entRd [STAGES];
  logic [AW-1:0]     srcReg [2];
  logic [1:0]        srcUsed;
  logic [1:0]        fwdHit;
  logic [1:0]        notReady;
  logic [DATA_W-1:0] fwdData [2];
  logic [AW-1:0]     effRd;
  logic              newValid;

  assign srcReg[0]  = src_a;
  assign srcReg[1]  = src_b;
  assign srcUsed    = {src_b_used, src_a_used};
  assign fwd_a_hit  = fwdHit[0];
  assign fwd_b_hit  = fwdHit[1];
  assign fwd_a_data = fwdData[0];
  assign fwd_b_data = fwdData[1];
  assign effRd      = issue_link ? LR : issue_rd;
  assign stall      = issue_valid && !flush && |notReady;
  assign newValid   = issue_valid && !stall && !flush && (issue_wr || issue_link) && effRd != ZR;

  // per-operand match: scanning oldest to youngest lets the youngest matching entry win
  always_comb begin
    for (int o = 0; o < 2; o++) begin
      fwdHit[o]   = 1'b0;
      notReady[o] = 1'b0;
      fwdData[o]  = '0;
      for (int k = STAGES-1; k >= 0; k--) begin
        if (srcUsed[o] && entValid[k] && entRd[k] == srcReg[o] && srcReg[o] != ZR) begin
          fwdHit[o]   = !(entLoad[k] && k < LOAD_LAT);
          notReady[o] = !fwdHit[o];
          fwdData[o]  = fwdHit[o] ? stage_data[k*DATA_W +: DATA_W] : '0;
        end
      end
    end
  end

  // population count of valid scoreboard entries
  always_comb begin
    inflight = '0;
    for (int k = 0; k < STAGES; k++)
      inflight = inflight + IW'(entValid[k]);
  end

  // scoreboard shifts every cycle; entry 0 takes the issuing instruction or a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entValid    <= '0;
      entLoad     <= '0;
      stall_count <= '0;
      for (int k = 0; k < STAGES; k++)
        entRd[k] <= '0;
    end else begin
      entValid    <= {entValid[STAGES-2:0], newValid};
      entLoad     <= {entLoad[STAGES-2:0], newValid && issue_load};
      entRd[0]    <= effRd;
      stall_count <= (stall && stall_count != 16'hFFFF) ? stall_count + 16'd1 : stall_count;
      for (int k = 1; k < STAGES; k++)
        entRd[k] <= entRd[k-1];
    end
  end
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: directed checks of forwarding, load-use stalls, flush and reset
module tb_pipe_hazard_unit;
  logic          clk = 1'b0;
  logic          reset;
  logic          issue_valid, issue_wr, issue_load, issue_link;
  logic [4:0]    issue_rd, src_a, src_b;
  logic          src_a_used, src_b_used, flush;
  logic [191:0]  stage_data;
  logic          stall, fwd_a_hit, fwd_b_hit;
  logic [63:0]   fwd_a_data, fwd_b_data;
  logic [15:0]   stall_count;
  logic [1:0]    inflight;
  int            checks = 0;
  int            errors = 0;

  pipe_hazard_unit dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_wr(issue_wr), .issue_load(issue_load), .issue_link(issue_link),
    .src_a(src_a), .src_b(src_b), .src_a_used(src_a_used), .src_b_used(src_b_used),
    .flush(flush), .stage_data(stage_data), .stall(stall), .fwd_a_hit(fwd_a_hit),
    .fwd_b_hit(fwd_b_hit), .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data),
    .stall_count(stall_count), .inflight(inflight)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [4:0] rd, input logic wr, input logic ld,
                       input logic lk, input logic [4:0] sa, input logic ua,
                       input logic [4:0] sb, input logic ub, input logic fl);
    issue_valid = v; issue_rd = rd; issue_wr = wr; issue_load = ld; issue_link = lk;
    src_a = sa; src_a_used = ua; src_b = sb; src_b_used = ub; flush = fl;
  endtask

  task automatic test_reset;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    stage_data = '0;
    reset = 1'b1;
    @(negedge clk);
    drive(1, 1, 1, 0, 0, 1, 1, 1, 1, 0);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", stall_count); end
    checks++; if (inflight !== 2'd0 || fwd_a_hit !== 1'b0 || fwd_b_hit !== 1'b0 || fwd_a_data !== 64'd0 || fwd_b_data !== 64'd0) begin
      errors++; $display("FAIL reset_outputs: got inflight=%0d hits=%b%b data=%h/%h expected all 0", inflight, fwd_a_hit, fwd_b_hit, fwd_a_data, fwd_b_data);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_alu_fwd;
    @(negedge clk);
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    stage_data[0 +: 64] = 64'h5;
    #1;
    checks++; if (fwd_a_hit !== 1'b1 || fwd_a_data !== 64'h5) begin errors++; $display("FAIL alu_fwd: got hit=%b data=%h expected 1/5", fwd_a_hit, fwd_a_data); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_nostall: got %b expected 0", stall); end
    checks++; if (inflight !== 2'd1) begin errors++; $display("FAIL alu_inflight: got %0d expected 1", inflight); end
  endtask

  task automatic test_load_use;
    @(negedge clk);
    drive(1, 2, 1, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 2, 1, 0);
    stage_data[0 +: 64] = 64'h11;
    stage_data[64 +: 64] = 64'hAB;
    #1;
    checks++; if (stall !== 1'b1 || fwd_b_hit !== 1'b0 || fwd_b_data !== 64'd0) begin
      errors++; $display("FAIL load_use_stall: got stall=%b hit=%b data=%h expected 1/0/0", stall, fwd_b_hit, fwd_b_data);
    end
    @(negedge clk);
    #1;
    checks++; if (stall !== 1'b0 || fwd_b_hit !== 1'b1 || fwd_b_data !== 64'hAB) begin
      errors++; $display("FAIL load_use_fwd: got stall=%b hit=%b data=%h expected 0/1/ab", stall, fwd_b_hit, fwd_b_data);
    end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL load_use_count: got %0d expected 1", stall_count); end
  endtask

  task automatic test_youngest;
    @(negedge clk);
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 3, 1, 4, 1, 0);
    stage_data = {64'h9, 64'h8, 64'h7};
    #1;
    checks++; if (fwd_a_data !== 64'h7 || fwd_a_hit !== 1'b1) begin errors++; $display("FAIL youngest_a: got hit=%b data=%h expected 1/7", fwd_a_hit, fwd_a_data); end
    checks++; if (fwd_b_data !== 64'h8 || fwd_b_hit !== 1'b1) begin errors++; $display("FAIL mid_entry_b: got hit=%b data=%h expected 1/8", fwd_b_hit, fwd_b_data); end
    checks++; if (inflight !== 2'd3) begin errors++; $display("FAIL full_inflight: got %0d expected 3", inflight); end
  endtask

  task automatic test_zero_reg;
    @(negedge clk);
    drive(1, 31, 1, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 31, 1, 0, 0, 0);
    #1;
    checks++; if (fwd_a_hit !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL zero_reg: got hit=%b stall=%b expected 0/0", fwd_a_hit, stall); end
    checks++; if (inflight !== 2'd0) begin errors++; $display("FAIL zero_inflight: got %0d expected 0", inflight); end
  endtask

  task automatic test_link;
    @(negedge clk);
    drive(1, 5, 0, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 30, 1, 0, 0, 0);
    stage_data[0 +: 64] = 64'h1234;
    #1;
    checks++; if (fwd_a_hit !== 1'b1 || fwd_a_data !== 64'h1234) begin errors++; $display("FAIL link_hit: got hit=%b data=%h expected 1/1234", fwd_a_hit, fwd_a_data); end
    src_a = 5;
    #1;
    checks++; if (fwd_a_hit !== 1'b0 || fwd_a_data !== 64'd0) begin errors++; $display("FAIL link_rd_ignored: got hit=%b data=%h expected 0/0", fwd_a_hit, fwd_a_data); end
  endtask

  task automatic test_flush;
    @(negedge clk);
    drive(1, 2, 1, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 6, 1, 0, 0, 2, 1, 0, 0, 1);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b expected 0", stall); end
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
    #1;
    checks++; if (inflight !== 2'd1 || fwd_a_hit !== 1'b0) begin errors++; $display("FAIL flush_bubble: got inflight=%0d hit=%b expected 1/0", inflight, fwd_a_hit); end
  endtask

  task automatic test_reset_mid_stall;
    @(negedge clk);
    drive(1, 2, 1, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL pre_reset_stall: got %b expected 1", stall); end
    reset = 1'b1;
    #1;
    checks++; if (stall !== 1'b0 || stall_count !== 16'd0 || inflight !== 2'd0) begin
      errors++; $display("FAIL async_reset: got stall=%b count=%0d inflight=%0d expected 0/0/0", stall, stall_count, inflight);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset;
    test_alu_fwd;
    test_reset;
    test_load_use;
    test_reset;
    test_youngest;
    test_reset;
    test_zero_reg;
    test_reset;
    test_link;
    test_reset;
    test_flush;
    test_reset;
    test_load_use;
    test_reset_mid_stall;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 Parameter DATA_W, default 64, operand/result width.
REQ-002 Parameter AW, default 5, register-address width.
REQ-003 Parameter STAGES, default 3, number of tracked post-issue stages (entry 0 = EX, 1 = MEM, 2 = WB).
REQ-004 Parameter LOAD_LAT, default 1, lowest entry index at which a load result is forwardable.
REQ-005 Parameter ZERO_REG, default 31, register that never produces a hazard or forward.
REQ-006 Parameter LINK_REG, default 30, destination substituted for link-writing instructions.
REQ-007 Port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-008 Port reset, input, 1, asynchronous, active-high; clears all state immediately.
REQ-009 Port issue_valid, input, 1, an instruction is in the register-fetch stage.
REQ-010 Port issue_rd, input, AW, destination register of the issuing instruction.
REQ-011 Port issue_wr, issue_load and issue_link, inputs, 1 each: writes a register; is a load; writes LINK_REG.
REQ-012 Port src_a and src_b, inputs, AW each, source registers; src_a_used and src_b_used, inputs, 1 each, source is read.
REQ-013 Port flush, input, 1, a branch was taken; the issuing instruction is squashed.
REQ-014 Port stage_data, input, STAGES*DATA_W, result of entry k in bits [k*DATA_W +: DATA_W].
REQ-015 Port stall, output, 1, holds the fetch stage and the register-fetch stage this cycle.
REQ-016 Ports fwd_a_hit and fwd_b_hit, outputs, 1 each, use forwarded data instead of register-file data.
REQ-017 Ports fwd_a_data and fwd_b_data, outputs, DATA_W each, forwarded operand values.
REQ-018 Port stall_count, output, 16, saturating count of stall cycles.
REQ-019 Port inflight, output, $clog2(STAGES+1), number of valid scoreboard entries.

Function
REQ-020 The unit SHALL hold STAGES scoreboard entries, each {valid, rd, load}.
REQ-021 The effective destination SHALL be LINK_REG when issue_link=1, and issue_rd otherwise.
REQ-022 An entry SHALL be valid only if its instruction had issue_wr=1 or issue_link=1, and its effective destination is not ZERO_REG.
REQ-023 Every cycle, entry k SHALL move to entry k+1; the content of entry STAGES-1 SHALL be discarded.
REQ-024 Entry 0 SHALL load the issuing instruction only when issue_valid=1, stall=0 and flush=0; otherwise entry 0 SHALL load a bubble (valid=0).
REQ-025 Operand A SHALL match entry k when src_a_used=1, entry k is valid, entry rd equals src_a, and src_a is not ZERO_REG; operand B SHALL be matched the same way.
REQ-026 When several entries match, the lowest index (youngest) SHALL win.
REQ-027 The winning entry SHALL be ready unless its load bit is 1 and k < LOAD_LAT.
REQ-028 When the winner is ready, fwd_x_hit SHALL be 1 and fwd_x_data SHALL equal stage_data of that entry, combinationally; otherwise fwd_x_hit SHALL be 0 and fwd_x_data SHALL be 0.
REQ-029 stall SHALL be 1 when issue_valid=1, flush=0, and either operand's winner is not ready.
REQ-030 Flush with a simultaneous load-use condition SHALL give stall=0 and insert a bubble; flush has priority.
REQ-031 stall_count SHALL increment on each cycle with stall=1 and hold at 16'hFFFF.
REQ-032 inflight SHALL equal the population count of the entry valid bits, combinationally.
REQ-033 Load-use latency SHALL be LOAD_LAT stall cycles for a consumer issued directly behind a load.
REQ-034 An ALU producer SHALL cause no stall.

Reset
REQ-035 While reset=1, all entries SHALL be invalid and stall_count SHALL be 0.
REQ-036 Consequently stall, both fwd_*_hit outputs, both fwd_*_data outputs and inflight SHALL read 0 during reset.
REQ-037 Reset asserted mid-stall SHALL drop stall in the same cycle, without waiting for a clock edge.

Verification
REQ-038 ADD X1 (entry 0), then consumer src_a=1 with stage_data[0]=64'h5 -> fwd_a_hit=1, fwd_a_data=5, stall=0.
REQ-039 LDUR X2 issued, then consumer src_b=2 next cycle -> stall=1 for exactly 1 cycle; the next cycle gives fwd_b_hit=1 with stage_data[1]; stall_count=1.
REQ-040 X3 written by entries 0 and 2 (values 7 and 9), src_a=3 -> fwd_a_data=7 (youngest wins).
REQ-041 Writer to X31, then consumer src_a=31 -> fwd_a_hit=0, stall=0, inflight=0.
REQ-042 BL (issue_link=1, issue_rd=5), then consumer src_a=30 -> hit on entry 0; a consumer with src_a=5 -> no hit.
REQ-043 Load-use condition with flush=1 -> stall=0 and a bubble in entry 0; separately, reset pulsed during a stall -> stall=0 and stall_count=0 immediately.
